// File: rtl/ocimem_arb_pkg.sv
// ocimem_arb_pkg: shared types and JTAG shift-word field positions for the OCI memory arbiter
package ocimem_arb_pkg;
    typedef enum logic [1:0] {IDLE, JT_RD, AV_RD} state_t;
    typedef enum logic [1:0] {LOAD, READ, WRITE} jreq_t;
    localparam int JDO_W     = 38;
    localparam int ADDR_LSB  = 26;
    localparam int RDFLAG    = 25;
    localparam int WDATA_LSB = 3;
endpackage

// File: rtl/ocimem_jtag_req.sv
// ocimem_jtag_req: captures JTAG ocimem strobes into one pending request and owns the JTAG address counter
//  in : clk, reset_n (async, active-low), jdo, take_action_ocimem_a/b, take_no_action_ocimem_a,
//       done (pending request retired), inc (advance jtag_addr)
//  out: jt_pend, jt_type, jt_wdata, jtag_addr, jtag_overrun (sticky)
module ocimem_jtag_req import ocimem_arb_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              done,
    input  logic              inc,
    output logic              jt_pend,
    output jreq_t             jt_type,
    output logic [DATA_W-1:0] jt_wdata,
    output logic [ADDR_W-1:0] jtag_addr,
    output logic              jtag_overrun
);
    logic strobe;
    logic accept;
    logic unused_jdo;
    assign strobe     = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign accept     = strobe && !jt_pend;
    assign unused_jdo = ^{jdo[JDO_W-1:WDATA_LSB+DATA_W], jdo[WDATA_LSB-1:0]};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jt_pend      <= 1'b0;
            jt_type      <= LOAD;
            jt_wdata     <= '0;
            jtag_addr    <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (strobe && jt_pend)
                jtag_overrun <= 1'b1;
            if (done)
                jt_pend <= 1'b0;
            else if (accept) begin
                // an address load without the read flag finishes here and never queues
                jt_pend  <= !(take_action_ocimem_a && !jdo[RDFLAG]);
                jt_type  <= take_action_ocimem_a ? LOAD : take_action_ocimem_b ? WRITE : READ;
                jt_wdata <= jdo[WDATA_LSB +: DATA_W];
            end
            if (accept && take_action_ocimem_a)
                jtag_addr <= jdo[ADDR_LSB +: ADDR_W];
            else if (inc)
                jtag_addr <= jtag_addr + 1'b1;
        end
    end
endmodule

// File: rtl/ocimem_access_arbiter.sv
// ocimem_access_arbiter: shares the single-port 256x32 OCI debug RAM between JTAG and the Avalon debug port
//  JTAG : jdo + take_action_ocimem_a/b, take_no_action_ocimem_a -> MonDReg, monitor_ready, jtag_overrun
//  Avalon: av_address/read/write/writedata/byteenable/debugaccess -> av_waitrequest, av_readdata
//  RAM  : ram_addr/wdata/be/wr/rd out, ram_rdata in (valid the cycle after ram_rd)
//  Build option OCIMEM_WR_PROTECT_EN: Avalon writes without av_debugaccess complete but never reach RAM
module ocimem_access_arbiter import ocimem_arb_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    input  logic              av_debugaccess,
    output logic              av_waitrequest,
    output logic [DATA_W-1:0] av_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);
`ifdef OCIMEM_WR_PROTECT_EN
    localparam logic WR_PROTECT = 1'b1;
`else
    localparam logic WR_PROTECT = 1'b0;
`endif
    state_t              state, state_nx;
    logic                rr, rr_nx;
    logic                jt_pend, jt_done, jt_inc;
    jreq_t               jt_type;
    logic [DATA_W-1:0]   jt_wdata;
    logic [ADDR_W-1:0]   jtag_addr;
    logic                av_req, grant_jt, grant_av;
    ocimem_jtag_req #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_jtag (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .done                    (jt_done),
        .inc                     (jt_inc),
        .jt_pend                 (jt_pend),
        .jt_type                 (jt_type),
        .jt_wdata                (jt_wdata),
        .jtag_addr               (jtag_addr),
        .jtag_overrun            (jtag_overrun)
    );
    // Avalon is masked during reset so no RAM strobe can escape while reset_n is low
    assign av_req        = reset_n && (av_read || av_write);
    assign grant_jt      = state == IDLE && jt_pend && (!av_req || !rr);
    assign grant_av      = state == IDLE && av_req && (!jt_pend || rr);
    assign monitor_ready = !jt_pend && state != JT_RD;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rr      <= 1'b0;
            MonDReg <= '0;
        end else begin
            state <= state_nx;
            rr    <= rr_nx;
            if (state == JT_RD)
                MonDReg <= ram_rdata;
        end
    end
    always_comb begin
        state_nx       = state;
        rr_nx          = rr;
        ram_addr       = jtag_addr;
        ram_wdata      = jt_wdata;
        ram_be         = '0;
        ram_wr         = 1'b0;
        ram_rd         = 1'b0;
        av_waitrequest = 1'b1;
        av_readdata    = '0;
        jt_done        = 1'b0;
        jt_inc         = 1'b0;
        case (state)
            IDLE: begin
                if (grant_jt) begin
                    rr_nx = 1'b1;
                    if (jt_type == WRITE) begin
                        ram_wr  = 1'b1;
                        ram_be  = 4'hF;
                        jt_done = 1'b1;
                        jt_inc  = 1'b1;
                    end else begin
                        ram_rd   = 1'b1;
                        state_nx = JT_RD;
                    end
                end else if (grant_av) begin
                    rr_nx          = 1'b0;
                    ram_addr       = av_address;
                    ram_wdata      = av_writedata;
                    ram_be         = av_byteenable;
                    av_waitrequest = av_read;
                    ram_rd         = av_read;
                    ram_wr         = !av_read && (!WR_PROTECT || av_debugaccess);
                    state_nx       = av_read ? AV_RD : IDLE;
                end
            end
            JT_RD: begin
                jt_done  = 1'b1;
                jt_inc   = 1'b1;
                state_nx = IDLE;
            end
            AV_RD: begin
                av_waitrequest = 1'b0;
                av_readdata    = ram_rdata;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ocimem_access_arbiter.sv
// tb_ocimem_access_arbiter: randomized bench against a transaction-level model of the OCI memory arbiter
module tb_ocimem_access_arbiter;
`ifdef OCIMEM_WR_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
    logic [7:0]  av_address = '0;
    logic        av_read = 1'b0, av_write = 1'b0;
    logic [31:0] av_writedata = '0;
    logic [3:0]  av_byteenable = '0;
    logic        av_debugaccess = 1'b0;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_wr, ram_rd;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, jtag_overrun;

    bit [31:0]   mem [256];
    bit [31:0]   ref_mem [256];
    logic [7:0]  rd_log [256];
    int          wr_cnt, rd_cnt;
    logic [7:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    logic [3:0]  last_wr_be;
    int          n_checks, n_pass;
    bit [7:0]    j_addr;
    bit          favor_av;

    ocimem_access_arbiter dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b), .take_no_action_ocimem_a(tna_a),
        .av_address(av_address), .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
        .av_byteenable(av_byteenable), .av_debugaccess(av_debugaccess),
        .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_wr(ram_wr), .ram_rd(ram_rd),
        .ram_rdata(ram_rdata), .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
            wr_cnt        <= wr_cnt + 1;
            last_wr_addr  <= ram_addr;
            last_wr_data  <= ram_wdata;
            last_wr_be    <= ram_be;
        end
        if (ram_rd) begin
            ram_rdata            <= mem[ram_addr];
            rd_log[rd_cnt[7:0]]  <= ram_addr;
            rd_cnt               <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // kind 0 = address load, 1 = write, 2 = read at current address
    task automatic jtag(input int kind, input logic [7:0] a, input bit flag, input logic [31:0] d);
        logic [63:0] r = {$urandom, $urandom};
        jdo = r[37:0];
        if (kind == 0) begin jdo[33:26] = a; jdo[25] = flag; ta_a = 1'b1; end
        else if (kind == 1) begin jdo[34:3] = d; ta_b = 1'b1; end
        else tna_a = 1'b1;
        @(negedge clk);
        ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!monitor_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, "_ready"}, monitor_ready, 1);
    endtask

    task automatic av_op(input bit rd, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                         input bit dbg, output logic [31:0] rdata, output int lat);
        bit done = 1'b0;
        lat = 0; rdata = '0;
        av_address = a; av_read = rd; av_write = !rd; av_writedata = d; av_byteenable = be; av_debugaccess = dbg;
        while (!done && lat < 20) begin
            #1;
            if (!av_waitrequest) begin done = 1'b1; rdata = av_readdata; end
            @(negedge clk);
            if (!done) lat++;
        end
        av_read = 1'b0; av_write = 1'b0;
        check("av_done", done, 1);
        #1 check("av_wait_rel", av_waitrequest, 1);
        @(negedge clk);
    endtask

    task automatic jt_read_done(input string tag, input int r0, input logic [7:0] a);
        wait_ready(tag);
        check({tag, "_nrd"}, rd_cnt - r0, 1);
        check({tag, "_addr"}, rd_log[r0[7:0]], a);
        check({tag, "_data"}, MonDReg, ref_mem[a]);
        j_addr = a + 8'd1;
        favor_av = 1'b1;
    endtask

    task automatic jt_read(input string tag);
        int r0 = rd_cnt;
        jtag(2, 8'h0, 1'b0, 32'h0);
        jt_read_done(tag, r0, j_addr);
    endtask

    task automatic jt_load(input string tag, input logic [7:0] a, input bit flag);
        int r0 = rd_cnt;
        jtag(0, a, flag, 32'h0);
        j_addr = a;
        if (flag) jt_read_done(tag, r0, a);
        else begin
            check({tag, "_ld_ready"}, monitor_ready, 1);
            @(negedge clk);
            check({tag, "_ld_nrd"}, rd_cnt - r0, 0);
        end
    endtask

    task automatic jt_write(input string tag, input logic [31:0] d);
        int w0 = wr_cnt;
        jtag(1, 8'h0, 1'b0, d);
        wait_ready(tag);
        check({tag, "_nwr"}, wr_cnt - w0, 1);
        check({tag, "_addr"}, last_wr_addr, j_addr);
        check({tag, "_data"}, last_wr_data, d);
        check({tag, "_be"}, last_wr_be, 4'hF);
        ref_mem[j_addr] = d;
        j_addr++;
        favor_av = 1'b1;
    endtask

    task automatic av_wr(input string tag, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, input bit dbg);
        int w0 = wr_cnt;
        int lat;
        logic [31:0] rd;
        bit hits = !(WP && !dbg);
        av_op(1'b0, a, d, be, dbg, rd, lat);
        check({tag, "_lat"}, lat, 0);
        check({tag, "_nwr"}, wr_cnt - w0, hits);
        if (hits) begin
            check({tag, "_addr"}, last_wr_addr, a);
            check({tag, "_be"}, last_wr_be, be);
            ref_mem[a] = merge(ref_mem[a], d, be);
        end
        favor_av = 1'b0;
    endtask

    task automatic av_rd(input string tag, input logic [7:0] a);
        int lat;
        logic [31:0] rd;
        av_op(1'b1, a, $urandom, 4'hF, 1'b1, rd, lat);
        check({tag, "_lat"}, lat, 1);
        check({tag, "_data"}, rd, ref_mem[a]);
        favor_av = 1'b0;
    endtask

    // JTAG read pending in the same IDLE cycle as an Avalon read; the favoured side goes first
    task automatic conc(input string tag);
        int r0 = rd_cnt;
        int lat;
        logic [7:0] ja = j_addr;
        logic [7:0] aa = j_addr + 8'd1 + 8'($urandom_range(0, 253));
        logic [31:0] rd;
        jtag(2, 8'h0, 1'b0, 32'h0);
        av_op(1'b1, aa, 32'h0, 4'hF, 1'b1, rd, lat);
        wait_ready(tag);
        check({tag, "_first"}, rd_log[r0[7:0]], favor_av ? aa : ja);
        check({tag, "_second"}, rd_log[8'(r0 + 1)], favor_av ? ja : aa);
        check({tag, "_avdata"}, rd, ref_mem[aa]);
        check({tag, "_jtdata"}, MonDReg, ref_mem[ja]);
        j_addr = ja + 8'd1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, w0;
        repeat (3) @(negedge clk);
        check("rst_wait", av_waitrequest, 1);
        check("rst_ready", monitor_ready, 1);
        check("rst_mon", MonDReg, 0);
        check("rst_ovr", jtag_overrun, 0);
        check("rst_strobes", {ram_wr, ram_rd}, 0);
        check("rst_avrd", av_readdata, 0);
        reset_n = 1'b1;
        @(negedge clk);
        j_addr = 8'h0; favor_av = 1'b0;

        jt_load("t1_ld", 8'h10, 1'b0);
        jt_write("t1_wr", 32'hA5A5_0001);
        r0 = rd_cnt;
        jtag(0, 8'h10, 1'b1, 32'h0);
        check("t1_busy0", monitor_ready, 0);
        @(negedge clk);
        check("t1_busy1", monitor_ready, 0);
        @(negedge clk);
        check("t1_mon", MonDReg, 32'hA5A5_0001);
        check("t1_ready", monitor_ready, 1);
        check("t1_rdaddr", rd_log[r0[7:0]], 8'h10);
        j_addr = 8'h11; favor_av = 1'b1;
        jt_write("t1_next", 32'h1111_2222);
        check("t1_addr11", last_wr_addr, 8'h11);

        jt_load("t2_ld", 8'hFF, 1'b0);
        jt_write("t2_wr", 32'hDEAD_BEEF);
        check("t2_wrap_model", j_addr, 8'h00);
        jt_read("t2_wrap");

        av_wr("t3_pre", 8'h40, 32'h0BAD_F00D, 4'hF, 1'b1);
        conc("t3_conc");

        r0 = rd_cnt; w0 = wr_cnt;
        check("t4_pre", jtag_overrun, 0);
        jtag(2, 8'h0, 1'b0, 32'h0);
        jtag(1, 8'h0, 1'b0, 32'h1234_5678);
        check("t4_ovr", jtag_overrun, 1);
        jt_read_done("t4_rd", r0, j_addr);
        check("t4_nowr", wr_cnt - w0, 0);
        repeat (3) @(negedge clk);
        check("t4_sticky", jtag_overrun, 1);

        av_wr("t5_nodbg", 8'h22, 32'hCAFE_0055, 4'b0101, 1'b0);
        av_rd("t5_rb", 8'h22);

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: jt_write("r_jwr", $urandom);
                1: jt_read("r_jrd");
                2: jt_load("r_jld", 8'($urandom), 1'($urandom));
                3: av_wr("r_awr", 8'($urandom), $urandom, 4'($urandom), 1'($urandom));
                4: av_rd("r_ard", 8'($urandom));
                default: conc("r_conc");
            endcase
        end

        av_address = 8'h22; av_read = 1'b1;
        @(negedge clk);
        #1 check("t6_avrd_state", av_waitrequest, 0);
        reset_n = 1'b0; av_read = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt;
        #1;
        check("t6_wait", av_waitrequest, 1);
        check("t6_mon", MonDReg, 0);
        check("t6_strobes", {ram_wr, ram_rd}, 0);
        check("t6_ovr", jtag_overrun, 0);
        check("t6_ready", monitor_ready, 1);
        @(negedge clk);
        check("t6_noacc", (rd_cnt - r0) + (wr_cnt - w0), 0);
        reset_n = 1'b1;
        @(negedge clk);
        j_addr = 8'h0; favor_av = 1'b0;
        jt_read("t6_addr0");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
